// File: rtl/tanh_share_ctrl.sv
// Round-robin time-sharing controller for a single tanh_lut among NREQ requesters.
// Holds the LUT phase across the lookup and queues tagged results in a small FIFO.
module tanh_share_ctrl #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned N       = 32,
  parameter int unsigned LUT_LAT = 1,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IW      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [N-1:0]        lut_phase,
  input  logic [N-1:0]        lut_tanh,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N-1:0]        rsp_data,
  output logic [IW-1:0]       rsp_id,
  output logic                busy
);

  localparam int unsigned WW = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = IW + N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wcnt, wcnt_nxt;
  logic [N-1:0]    phase_reg, phase_nxt;
  logic [IW-1:0]   tag, tag_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [IW-1:0]   idx_w, win_idx;
  logic [N-1:0]    win_phase;
  logic            win_found, inflight, space_ok, grant;
  logic            push, pop;
  logic [CW-1:0]   count, count_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [EW-1:0]   head_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [N-1:0]    req_phase [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_phase[g] = req_data[g*N +: N];
  end

  // Round-robin search starting at rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_w     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_w = IW'((32'(rr_ptr) + k) % NREQ);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  // Credit: the in-flight lookup reserves a slot; a same-cycle pop does not free one
  assign inflight  = (state != IDLE);
  assign space_ok  = (32'(count) + 32'(inflight)) < DEPTH;
  assign grant     = win_found && space_ok && ((state == IDLE) || (state == CAPT));
  assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;
  assign win_phase = req_phase[win_idx];
  assign lut_phase = phase_reg;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    phase_nxt = phase_reg;
    tag_nxt   = tag;
    rr_nxt    = rr_ptr;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          phase_nxt = win_phase;
          tag_nxt   = win_idx;
          wcnt_nxt  = '0;
          rr_nxt    = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        wcnt_nxt = wcnt + 1'b1;
        if (wcnt == WW'(LUT_LAT-1)) state_nxt = CAPT;
      end
      CAPT: begin
        push = 1'b1;
        if (grant) begin
          phase_nxt = win_phase;
          tag_nxt   = win_idx;
          wcnt_nxt  = '0;
          rr_nxt    = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO bookkeeping; the head register is preloaded with whatever will be at rd_ptr next
  assign pop        = rsp_valid & rsp_ready;
  assign count_nxt  = count + CW'(push) - CW'(pop);
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  assign head_nxt   = (push && (count == CW'(pop))) ? {tag, lut_tanh} : mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      phase_reg <= '0;
      tag       <= '0;
      rr_ptr    <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      phase_reg <= phase_nxt;
      tag       <= tag_nxt;
      rr_ptr    <= rr_nxt;
      count     <= count_nxt;
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr_nxt;
      rsp_valid <= (count_nxt != '0);
      {rsp_id, rsp_data} <= head_nxt;
      busy      <= (state_nxt != IDLE) || (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {tag, lut_tanh};
  end

endmodule

// File: tb/tb_tanh_share_ctrl.sv
// Self-checking bench for tanh_share_ctrl: cycle-level reference model plus
// a vector table and directed multi-cycle sequences.
module tb_tanh_share_ctrl;

  localparam int NREQ  = 4;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic               clk, rst;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*N-1:0]  req_data;
  logic [N-1:0]       lut_phase, lut_tanh, rsp_data, addr_r;
  logic               rsp_valid, rsp_ready, busy;
  logic [IW-1:0]      rsp_id;

  tanh_share_ctrl #(.NREQ(NREQ), .N(N), .LUT_LAT(1), .DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .lut_phase(lut_phase), .lut_tanh(lut_tanh),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in LUT: registered part from the previous-cycle phase, combinational part from the current one
  function automatic logic [N-1:0] gfun(input logic [N-1:0] x);
    return (x * 32'd3) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [N-1:0] lutf(input logic [N-1:0] p);
    return gfun(p) + {24'd0, p[7:0]};
  endfunction
  always_ff @(posedge clk) addr_r <= lut_phase;
  assign lut_tanh = gfun(addr_r) + {24'd0, lut_phase[7:0]};

  typedef struct packed {
    logic [IW-1:0] id;
    logic [N-1:0]  data;
  } rsp_t;

  typedef struct {
    logic [NREQ-1:0] v;
    logic [N-1:0]    phase;
    int              exp_id;
    logic [N-1:0]    exp_data;
  } vec_t;

  int n_checks, n_err;
  int cyc, tg, ptr_m, n_grant, dut_pops;
  logic [N-1:0] phase_m;
  rsp_t sb_q[$];
  rsp_t pend;

  logic [NREQ-1:0] g_ready;
  logic            g_rsp_valid, g_busy;
  logic [IW-1:0]   g_rsp_id;
  logic [N-1:0]    g_rsp_data, g_phase;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    tg = -100; ptr_m = 0; phase_m = '0; n_grant = 0; dut_pops = 0;
    sb_q.delete();
  endtask

  function automatic logic [NREQ*N-1:0] rep(input logic [N-1:0] p);
    return {NREQ{p}};
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] x);
    for (int k = 0; k < NREQ; k++) if (x[k]) return k;
    return -1;
  endfunction

  // One clock cycle: drive, compare against model at negedge, advance model at posedge
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*N-1:0] d,
                       input logic rr, input logic r);
    logic [NREQ-1:0] exp_rdy;
    logic            elig, exp_busy;
    int              win;
    req_valid = v; req_data = d; rsp_ready = rr; rst = r;
    @(negedge clk);
    g_ready = req_ready; g_rsp_valid = rsp_valid; g_rsp_id = rsp_id;
    g_rsp_data = rsp_data; g_busy = busy; g_phase = lut_phase;
    win = -1;
    for (int k = 0; k < NREQ; k++)
      if (win < 0 && v[(ptr_m + k) % NREQ]) win = (ptr_m + k) % NREQ;
    elig = (cyc >= tg + 2) && ((sb_q.size() + ((cyc == tg + 2) ? 1 : 0)) < DEPTH);
    exp_rdy = (win >= 0 && elig) ? (NREQ'(1) << win) : '0;
    exp_busy = (cyc <= tg + 2) || (sb_q.size() > 0);
    if (!r) begin
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(sb_q.size() > 0));
      if (sb_q.size() > 0) begin
        chk("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
        chk("rsp_data", 64'(rsp_data), 64'(sb_q[0].data));
      end
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("lut_phase", 64'(lut_phase), 64'(phase_m));
      if (rsp_valid && rr) dut_pops++;
    end
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (sb_q.size() > 0 && rr) void'(sb_q.pop_front());
      if (cyc == tg + 2) sb_q.push_back(pend);
      if (exp_rdy != '0) begin
        tg = cyc;
        pend.id = IW'(win);
        pend.data = lutf(d[win*N +: N]);
        phase_m = d[win*N +: N];
        ptr_m = (win + 1) % NREQ;
        n_grant++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    repeat (2) cycle('0, '0, 1'b0, 1'b1);
  endtask

  vec_t tbl[7];
  int   gq[$], gt[$], rq[$];
  logic [N-1:0] rd[$];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ng, nr, changes, lat;
    bit got;
    logic [NREQ-1:0] pm;
    logic [NREQ*N-1:0] d;
    logic [N-1:0] prev;
    n_checks = 0; n_err = 0; cyc = 0;
    model_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;

    // Vectors apply in order; rr_ptr carries over, so multi-bit entries depend on the previous grant
    tbl[0] = '{4'b0100, 32'h0000_8000, 2, lutf(32'h0000_8000)};
    tbl[1] = '{4'b0001, 32'h0002_0000, 0, lutf(32'h0002_0000)};
    tbl[2] = '{4'b1000, 32'hFFFE_0000, 3, lutf(32'hFFFE_0000)};
    tbl[3] = '{4'b0010, 32'h0000_0000, 1, lutf(32'h0000_0000)};
    tbl[4] = '{4'b0101, 32'h1234_5678, 2, lutf(32'h1234_5678)};
    tbl[5] = '{4'b1001, 32'hDEAD_BEEF, 3, lutf(32'hDEAD_BEEF)};
    tbl[6] = '{4'b0011, 32'h7FFF_FFFF, 0, lutf(32'h7FFF_FFFF)};

    do_reset();
    cycle('0, '0, 1'b0, 1'b0);
    chk("rst_rsp_valid", 64'(g_rsp_valid), 64'(0));
    chk("rst_busy", 64'(g_busy), 64'(0));
    chk("rst_phase", 64'(g_phase), 64'(0));
    chk("rst_rsp_data", 64'(g_rsp_data), 64'(0));
    chk("rst_rsp_id", 64'(g_rsp_id), 64'(0));

    // Table: single requests, latency and data
    for (int i = 0; i < 7; i++) begin
      got = 0;
      for (int t = 0; t < 10 && !got; t++) begin
        cycle(tbl[i].v, rep(tbl[i].phase), 1'b1, 1'b0);
        if (g_ready != '0) got = 1;
      end
      chk("tbl_grant", 64'(g_ready), 64'(NREQ'(1) << tbl[i].exp_id));
      lat = 0; got = 0;
      for (int t = 1; t <= 10 && !got; t++) begin
        cycle('0, '0, 1'b1, 1'b0);
        if (g_rsp_valid) begin got = 1; lat = t; end
      end
      chk("tbl_latency", 64'(lat), 64'(3));
      chk("tbl_id", 64'(g_rsp_id), 64'(tbl[i].exp_id));
      chk("tbl_data", 64'(g_rsp_data), 64'(tbl[i].exp_data));
    end

    // Fairness
    do_reset();
    gq.delete(); gt.delete(); rq.delete();
    for (int t = 0; t < 22; t++) begin
      cycle((t < 16) ? 4'b1111 : 4'b0000, rep(32'(t) << 12), 1'b1, 1'b0);
      if (g_ready != '0) begin gq.push_back(oh2i(g_ready)); gt.push_back(t); end
      if (g_rsp_valid) rq.push_back(int'(g_rsp_id));
    end
    chk("fair_ngrant", 64'(gq.size()), 64'(8));
    chk("fair_nrsp", 64'(rq.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < gq.size()) begin
        chk("fair_order", 64'(gq[i]), 64'(i % 4));
        chk("fair_gap", 64'(gt[i]), 64'(2 * i));
      end
      if (i < rq.size()) chk("fair_rsp_id", 64'(rq[i]), 64'(i % 4));
    end

    // Back-pressure
    do_reset();
    ng = 0;
    for (int t = 0; t < 12; t++) begin
      cycle(4'b1111, rep(32'h0001_0000 + 32'(t)), 1'b0, 1'b0);
      if (g_ready != '0) ng++;
    end
    chk("bp_grants", 64'(ng), 64'(DEPTH));
    chk("bp_ready_low", 64'(g_ready), 64'(0));
    chk("bp_busy", 64'(g_busy), 64'(1));
    cycle(4'b1111, rep(32'h0005_0000), 1'b1, 1'b0);
    chk("bp_head_id", 64'(g_rsp_id), 64'(0));
    chk("bp_no_credit", 64'(g_ready), 64'(0));
    cycle(4'b1111, rep(32'h0006_0000), 1'b1, 1'b0);
    chk("bp_resume", 64'(g_ready != '0), 64'(1));
    repeat (16) cycle('0, '0, 1'b1, 1'b0);

    // Phase stability across back-to-back lookups
    do_reset();
    pm = 4'b0110; d = '0;
    d[1*N +: N] = 32'h0002_0000;
    d[2*N +: N] = 32'hFFFE_0000;
    rd.delete(); prev = '0; changes = 0;
    for (int t = 0; t < 12; t++) begin
      cycle(pm, d, 1'b1, 1'b0);
      pm = pm & ~g_ready;
      if (g_phase != prev) changes++;
      prev = g_phase;
      if (g_rsp_valid) rd.push_back(g_rsp_data);
    end
    chk("ps_changes", 64'(changes), 64'(2));
    chk("ps_nrsp", 64'(rd.size()), 64'(2));
    if (rd.size() == 2) begin
      chk("ps_rsp_pos", 64'(rd[0]), 64'(lutf(32'h0002_0000)));
      chk("ps_rsp_neg", 64'(rd[1]), 64'(lutf(32'hFFFE_0000)));
    end

    // Reset while in WAIT with two FIFO entries
    do_reset();
    repeat (5) cycle(4'b1111, rep(32'h0003_0000), 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b1, 1'b0);
    chk("rm_valid", 64'(g_rsp_valid), 64'(0));
    chk("rm_busy", 64'(g_busy), 64'(0));
    chk("rm_phase", 64'(g_phase), 64'(0));
    cycle(4'b1111, rep(32'h0004_0000), 1'b1, 1'b0);
    chk("rm_grant", 64'(g_ready), 64'(4'b0001));
    nr = 0;
    for (int t = 0; t < 10; t++) begin
      cycle('0, '0, 1'b1, 1'b0);
      if (g_rsp_valid) begin
        nr++;
        chk("rm_data", 64'(g_rsp_data), 64'(lutf(32'h0004_0000)));
      end
    end
    chk("rm_nrsp", 64'(nr), 64'(1));

    // Push and pop together at count DEPTH-1
    do_reset();
    for (int t = 0; t < 8; t++) cycle(4'b1111, rep(32'h0000_1100 * 32'(t + 1)), 1'b0, 1'b0);
    cycle(4'b1111, rep(32'h0009_0000), 1'b1, 1'b0);
    chk("fp_no_grant", 64'(g_ready), 64'(0));
    cycle(4'b1111, rep(32'h000A_0000), 1'b1, 1'b0);
    chk("fp_grant_after", 64'(g_ready != '0), 64'(1));
    repeat (20) cycle('0, '0, 1'b1, 1'b0);
    chk("fp_pops", 64'(dut_pops), 64'(n_grant));
    chk("fp_drained", 64'(g_rsp_valid), 64'(0));

    // Random traffic with occasional resets
    do_reset();
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < NREQ; k++) d[k*N +: N] = $urandom();
      cycle(NREQ'($urandom()), d, ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
    end
    repeat (20) cycle('0, '0, 1'b1, 1'b0);
    chk("rnd_drained", 64'(g_rsp_valid), 64'(0));
    chk("rnd_idle", 64'(g_busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
